// File: rtl/binary_entry_pkg.sv
// rtl/binary_entry_pkg.sv - shared FSM state type and default word width for the binary word assembler
package binary_entry_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } asm_state_e;

endpackage

// File: rtl/binary_word_assembler_if.sv
// rtl/binary_word_assembler_if.sv - bit entry / word output bundle; parity_out exists only with BINARY_WORD_PARITY_EN
interface binary_word_assembler_if
    import binary_entry_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                         bit_valid;
    logic                         bit_in;
    logic                         end_in;
    logic                         ready;
    logic [WIDTH-1:0]             word_out;
    logic                         word_valid;
    logic                         partial;
    logic [$clog2(WIDTH+1)-1:0]   bit_count;
`ifdef BINARY_WORD_PARITY_EN
    logic                         parity_out;

    modport master (output bit_valid, bit_in, end_in,
                    input  ready, word_out, word_valid, partial, bit_count, parity_out);
    modport slave  (input  bit_valid, bit_in, end_in,
                    output ready, word_out, word_valid, partial, bit_count, parity_out);
`else
    modport master (output bit_valid, bit_in, end_in,
                    input  ready, word_out, word_valid, partial, bit_count);
    modport slave  (input  bit_valid, bit_in, end_in,
                    output ready, word_out, word_valid, partial, bit_count);
`endif
endinterface

// File: rtl/bit_shift_reg.sv
// rtl/bit_shift_reg.sv - shift register and bit counter with MSB_FIRST bit placement
module bit_shift_reg #(
    parameter int  WIDTH     = 8,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_next_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] shift_q, shift_d, placed;
    logic [CW-1:0]    count_q, count_d;

    // MSB-first shifts left so a short word ends up right-aligned; LSB-first drops bit k at index k
    if (MSB_FIRST) begin : g_msb
        assign placed = {shift_q[WIDTH-2:0], bit_i};
    end else begin : g_lsb
        assign placed = shift_q | (WIDTH'(bit_i) << count_q);
    end

    // The word as it will stand after this cycle's accepted bit, so the top can latch it in the same edge
    assign word_next_o = load_i ? placed : shift_q;
    assign count_o     = count_q;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (clear_i) begin
            shift_d = '0;
            count_d = '0;
        end else if (load_i) begin
            shift_d = placed;
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/binary_word_assembler.sv
// rtl/binary_word_assembler.sv - collects serial binary digits into WIDTH-bit words; BINARY_WORD_PARITY_EN adds parity_out
module binary_word_assembler
    import binary_entry_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    binary_word_assembler_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    asm_state_e       state_q, state_d;
    logic             ready, accept_bit, accept_end;
    logic             emit_go, partial_go;
    logic [WIDTH-1:0] word_next, word_q;
    logic             valid_q, partial_q;
    logic [CW-1:0]    count;

    assign ready      = (state_q != EMIT);
    assign accept_bit = ready & bus.bit_valid;
    assign accept_end = ready & bus.end_in;

    bit_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept_bit),
        .clear_i     (state_q == EMIT),
        .bit_i       (bus.bit_in),
        .word_next_o (word_next),
        .count_o     (count)
    );

    always_comb begin
        state_d    = state_q;
        emit_go    = 1'b0;
        partial_go = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                // A bit arriving with end_in is taken first; it only counts as full if it completes the word
                if (accept_bit && count == CW'(WIDTH - 1)) begin
                    emit_go = 1'b1;
                end else if (accept_end && (accept_bit || count != '0)) begin
                    emit_go    = 1'b1;
                    partial_go = 1'b1;
                end
                if (emit_go) begin
                    state_d = EMIT;
                end else if (accept_bit) begin
                    state_d = COLLECT;
                end
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs load on the edge entering EMIT so word_valid is high throughout the EMIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            valid_q   <= emit_go;
            partial_q <= partial_go;
            if (emit_go) begin
                word_q <= word_next;
            end
        end
    end

`ifdef BINARY_WORD_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (emit_go) begin
            parity_q <= ^word_next;
        end
    end

    assign bus.parity_out = parity_q;
`endif

    assign bus.ready      = ready;
    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.partial    = partial_q;
    assign bus.bit_count  = count;
endmodule

// File: tb/tb_binary_word_assembler.sv
// tb/tb_binary_word_assembler.sv - self-checking bench driving MSB-first and LSB-first assemblers in lockstep
module tb_binary_word_assembler;
    import binary_entry_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    binary_word_assembler_if #(.WIDTH(W)) ifa ();
    binary_word_assembler_if #(.WIDTH(W)) ifb ();

    binary_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(ifa));
    binary_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          m_busy;
    int          m_bits[$];
    logic [31:0] m_wmsb, m_wlsb;
    bit          m_valid, m_partial;

    int          pulses;
    logic [31:0] got_msb[$];
    logic [31:0] got_lsb[$];
    bit          got_partial[$];

    typedef struct {
        int          nbits;
        logic [31:0] bits;
        bit          end_last;
        bit          end_after;
        logic [7:0]  exp_msb;
        logic [7:0]  exp_lsb;
        bit          exp_partial;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] assemble(input bit msb_first);
        logic [31:0] w;
        int n;
        w = 32'd0;
        n = m_bits.size();
        for (int i = 0; i < n; i++) begin
            if (m_bits[i] != 0) w += msb_first ? (32'd1 << (n - 1 - i)) : (32'd1 << i);
        end
        return w;
    endfunction

    task automatic model_clear();
        m_busy = 1'b0;
        m_bits.delete();
        m_wmsb = 32'd0;
        m_wlsb = 32'd0;
        m_valid = 1'b0;
        m_partial = 1'b0;
    endtask

    task automatic model_step(input bit bv, input bit bi, input bit ei);
        bit full;
        m_valid = 1'b0;
        m_partial = 1'b0;
        if (m_busy) begin
            m_busy = 1'b0;
            m_bits.delete();
        end else begin
            if (bv) m_bits.push_back(int'(bi));
            full = bv && (m_bits.size() == W);
            if (full || (ei && m_bits.size() > 0)) begin
                m_valid = 1'b1;
                m_partial = !full;
                m_busy = 1'b1;
                m_wmsb = assemble(1'b1);
                m_wlsb = assemble(1'b0);
            end
        end
    endtask

    task automatic compare_all();
        chk("ready_msb", 32'(ifa.ready), 32'(!m_busy));
        chk("ready_lsb", 32'(ifb.ready), 32'(!m_busy));
        chk("valid_msb", 32'(ifa.word_valid), 32'(m_valid));
        chk("valid_lsb", 32'(ifb.word_valid), 32'(m_valid));
        chk("partial_msb", 32'(ifa.partial), 32'(m_partial));
        chk("partial_lsb", 32'(ifb.partial), 32'(m_partial));
        chk("word_msb", 32'(ifa.word_out), m_wmsb);
        chk("word_lsb", 32'(ifb.word_out), m_wlsb);
        chk("count_msb", 32'(ifa.bit_count), 32'(m_bits.size()));
        chk("count_lsb", 32'(ifb.bit_count), 32'(m_bits.size()));
`ifdef BINARY_WORD_PARITY_EN
        chk("parity_msb", 32'(ifa.parity_out), 32'(^m_wmsb));
        chk("parity_lsb", 32'(ifb.parity_out), 32'(^m_wlsb));
`endif
    endtask

    task automatic drive(input bit bv, input bit bi, input bit ei);
        ifa.bit_valid = bv; ifa.bit_in = bi; ifa.end_in = ei;
        ifb.bit_valid = bv; ifb.bit_in = bi; ifb.end_in = ei;
    endtask

    task automatic cycle(input bit bv, input bit bi, input bit ei);
        drive(bv, bi, ei);
        @(posedge clk);
        model_step(bv, bi, ei);
        #1;
        compare_all();
        if (ifa.word_valid === 1'b1) begin
            pulses++;
            got_msb.push_back(32'(ifa.word_out));
            got_lsb.push_back(32'(ifb.word_out));
            got_partial.push_back(ifa.partial);
        end
    endtask

    task automatic clear_rec();
        pulses = 0;
        got_msb.delete();
        got_lsb.delete();
        got_partial.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) cycle(1'b1, b[7 - k], 1'b0);
    endtask

    task automatic send_held(input bit b);
        bit r;
        for (int t = 0; t < 4; t++) begin
            r = ifa.ready;
            cycle(1'b1, b, 1'b0);
            if (r) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        model_clear();
        clear_rec();
        @(posedge clk);
        #1;
        chk("rst_word", 32'(ifa.word_out), 32'd0);
        chk("rst_valid", 32'(ifa.word_valid), 32'd0);
        chk("rst_partial", 32'(ifa.partial), 32'd0);
        chk("rst_count", 32'(ifa.bit_count), 32'd0);
        rst = 1'b0;
        chk("ready_after_rst", 32'(ifa.ready), 32'd1);

        vecs[0] = '{8, 32'b10110010, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b0};
        vecs[1] = '{3, 32'b110,      1'b0, 1'b1, 8'h06, 8'h03, 1'b1};
        vecs[2] = '{8, 32'b10000001, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0};
        vecs[3] = '{2, 32'b11,       1'b0, 1'b1, 8'h03, 8'h03, 1'b1};
        vecs[4] = '{8, 32'b11100001, 1'b1, 1'b0, 8'hE1, 8'h87, 1'b0};
        vecs[5] = '{3, 32'b101,      1'b1, 1'b0, 8'h05, 8'h05, 1'b1};

        for (int v = 0; v < 6; v++) begin
            clear_rec();
            for (int k = 0; k < vecs[v].nbits; k++)
                cycle(1'b1, vecs[v].bits[vecs[v].nbits - 1 - k], (k == vecs[v].nbits - 1) && vecs[v].end_last);
            if (vecs[v].end_after) cycle(1'b0, 1'b0, 1'b1);
            repeat (3) cycle(1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd1);
            if (pulses > 0) begin
                chk($sformatf("vec%0d_word_msb", v), got_msb[0], 32'(vecs[v].exp_msb));
                chk($sformatf("vec%0d_word_lsb", v), got_lsb[0], 32'(vecs[v].exp_lsb));
                chk($sformatf("vec%0d_partial", v), 32'(got_partial[0]), 32'(vecs[v].exp_partial));
            end
        end

        clear_rec();
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        chk("idle_end_pulses", 32'(pulses), 32'd0);

        clear_rec();
        send_byte(8'h0F);
        chk("emit_ready", 32'(ifa.ready), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        send_byte(8'h3C);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("emit_ignore_pulses", 32'(pulses), 32'd2);
        if (pulses >= 2) begin
            chk("emit_ignore_w0_msb", got_msb[0], 32'h0F);
            chk("emit_ignore_w1_msb", got_msb[1], 32'h3C);
            chk("emit_ignore_w0_lsb", got_lsb[0], 32'hF0);
            chk("emit_ignore_w1_lsb", got_lsb[1], 32'h3C);
        end

        clear_rec();
        for (int k = 0; k < 8; k++) send_held(k[0]);
        for (int k = 0; k < 8; k++) send_held(!k[0]);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("stream_pulses", 32'(pulses), 32'd2);
        if (pulses >= 2) begin
            chk("stream_w0_msb", got_msb[0], 32'h55);
            chk("stream_w1_msb", got_msb[1], 32'hAA);
            chk("stream_w0_lsb", got_lsb[0], 32'hAA);
            chk("stream_w1_lsb", got_lsb[1], 32'h55);
        end

        clear_rec();
        repeat (5) cycle(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midword_rst_count", 32'(ifa.bit_count), 32'd0);
        chk("midword_rst_valid", 32'(ifa.word_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midword_rst_ready", 32'(ifa.ready), 32'd1);
        send_byte(8'hFF);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("after_rst_pulses", 32'(pulses), 32'd1);
        if (pulses >= 1) begin
            chk("after_rst_word_msb", got_msb[0], 32'hFF);
            chk("after_rst_word_lsb", got_lsb[0], 32'hFF);
        end

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
